// File: rtl/univ_shift_register.sv
// univ_shift_register: universal shift register with burst controller.
// Define UNIV_SHREG_ROTATE_EN to build rotate mode (op=01); otherwise op=01 holds.
module univ_shift_register #(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      STEP   = 1,
    parameter logic [WIDTH-1:0] AVALUE = WIDTH'(8'h05),
    parameter logic [WIDTH-1:0] SVALUE = '1,
    parameter int unsigned      CNT_W  = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             aset,
    input  logic             sclr,
    input  logic             sset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [1:0]       op,
    input  logic [STEP-1:0]  shiftin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  shiftout,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d, sh_val;
    logic [STEP-1:0]  so_q, so_d, sh_out, fill, rot_fill;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, do_shift;

`ifdef UNIV_SHREG_ROTATE_EN
    assign do_shift = op != 2'b11;
    assign rot_fill = dir ? reg_q[STEP-1:0] : reg_q[WIDTH-1:WIDTH-STEP];
`else
    assign do_shift = !op[0];
    assign rot_fill = '0;
`endif

    // Every mode moves the same bits out; only the vacated fill differs.
    always_comb begin
        fill   = op[1] ? (dir ? {STEP{reg_q[WIDTH-1]}} : '0) : (op[0] ? rot_fill : shiftin);
        sh_val = dir ? {fill, reg_q[WIDTH-1:STEP]} : {reg_q[WIDTH-1-STEP:0], fill};
        sh_out = dir ? reg_q[STEP-1:0] : reg_q[WIDTH-1:WIDTH-STEP];
    end

    always_comb begin
        reg_d   = reg_q;
        so_d    = so_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (sclr || sset) begin
            reg_d   = sclr ? '0 : SVALUE;
            so_d    = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (en && load)
                reg_d = data;
            if (start) begin
                state_d = (count != '0) ? BUSY : IDLE;
                cnt_d   = count;
                done_d  = count == '0;
            end else if (en && !load && do_shift) begin
                reg_d = sh_val;
                so_d  = sh_out;
            end
        end else if (en) begin
            // Hold ops inside a burst still consume a count.
            if (do_shift) begin
                reg_d = sh_val;
                so_d  = sh_out;
            end
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? IDLE : BUSY;
            done_d  = cnt_q == CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge aclr or posedge aset) begin
        if (aclr) begin
            reg_q   <= '0;
            so_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (aset) begin
            reg_q   <= AVALUE;
            so_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            reg_q   <= reg_d;
            so_q    <= so_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q        = reg_q;
    assign shiftout = so_q;
    assign busy     = state_q == BUSY;
    assign done     = done_q;
endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register for the datapath shift/serialisation slice. It supports runtime-selectable direction, logical, rotate and arithmetic modes, and a configurable multi-bit step. A burst controller executes a programmed number of shifts and reports `busy`/`done`. It keeps the async/sync clear/set and parallel-load priority of the earlier fixed-width register and adds controllable serial streaming on top.

## Interface
- `WIDTH`, 8: register width, ≥2.
- `STEP`, 1: bits moved per shift operation, 1..WIDTH-1.
- `AVALUE`, 8'h05: value forced by `aset`, zero-extended or truncated to WIDTH.
- `SVALUE`, all ones: value loaded by `sset`.
- `CNT_W`, 4: width of burst count.
- `clk` in 1: clock, rising edge.
- `aclr` in 1: reset, asynchronous, active-high.
- `aset` in 1: async set to AVALUE, active-high.
- `sclr` in 1: sync clear.
- `sset` in 1: sync set to SVALUE.
- `en` in 1: clock enable for load/shift; stalls bursts.
- `load` in 1: parallel load of `data` (needs `en`).
- `data` in WIDTH: parallel load data.
- `dir` in 1: 0 = left (toward MSB), 1 = right.
- `op` in 2: 00 logical, 01 rotate, 10 arithmetic, 11 hold.
- `shiftin` in STEP: serial fill bits for logical mode.
- `start` in 1: request a burst of `count` shifts.
- `count` in CNT_W: burst length, sampled with `start`.
- `q` out WIDTH: register contents.
- `shiftout` out STEP: bits most recently shifted or rotated out.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
**Priority**, highest first: `aclr`, `aset`, `sclr`, `sset`, `en&load`, shift.

**Reset and set behaviour**
- `aclr`: q=0, shiftout=0, busy=0, done=0, state IDLE, burst counter 0.
- `aset`: q=AVALUE, shiftout=0, state IDLE, done=0.
- `sclr`/`sset`: force q, clear shiftout, abort any burst to IDLE with no `done`.

**Shift modes**
- Logical left: q={q[W-1-STEP:0],shiftin}; shiftout=q[W-1:W-STEP].
- Logical right: q={shiftin,q[W-1:STEP]}; shiftout=q[STEP-1:0].
- Rotate: the vacated bits take the bits that leave; shiftout = those bits; `shiftin` is ignored.
- Arithmetic right: fill with STEP copies of q[W-1]; shiftout=q[STEP-1:0].
- Arithmetic left: identical to logical left with zero fill; `shiftin` is ignored.
- op=11: no shift; q and shiftout hold.

**States**
- IDLE:
  - `en&!load&!start`: one shift per cycle (legacy streaming).
  - `start`, count>0: latch count, go to BUSY; no shift on that edge.
  - `start`, count=0: stay IDLE, pulse done next cycle.
- BUSY:
  - On each edge with `en`: one shift, counter decrements.
  - On the edge where counter=1 and `en`: final shift, go to IDLE, done=1 for the following cycle.
  - `en`=0 stalls with q held.
  - `load` and `start` are ignored.
  - `dir`/`op`/`shiftin` are sampled live every shift.
- `busy`=1 exactly while in BUSY. `done` is registered and cleared on the next edge.

## Timing
- All state is registered; q, shiftout, busy and done change only on `clk` edges, except under `aclr`/`aset`.
- Load latency 1 cycle. Shift latency 1 cycle per operation.
- Burst of N with `en` held high: busy high for N cycles starting the cycle after `start`; done high in cycle N+1.
- Async controls act immediately, and their deassertion takes effect at the next edge.

## Configuration
- `UNIV_SHREG_ROTATE_EN` defined: op=01 performs rotate as specified.
- Not defined: rotate logic is not built; op=01 behaves as op=11 (hold), including within bursts, where the counter still decrements.

## Test plan
- Load then single shift: WIDTH=8, load 0x81, then dir=1, op=00, shiftin=1, one `en` cycle -> q=0xC0, shiftout=1.
- Arithmetic burst: load 0x96, dir=1, op=10, start with count=3, en high -> busy for 3 cycles, q=0xF2, shiftout=1, done pulse in cycle 4.
- Multi-bit rotate: STEP=2 with rotate enabled, load 0xA5, dir=0, op=01, one shift -> q=0x96, shiftout=2'b10. With the macro undefined -> q stays 0xA5.
- Stall and abort: burst count=4 with `en` low for 2 mid-burst cycles -> q holds and busy stays high. `sclr` during a second burst -> q=0, busy=0, and no done.
- Async priority: assert `aclr` and `aset` together mid-burst -> q=0 immediately. Release `aclr` -> q=0x05, busy=0.
- Zero-length burst: start with count=0 -> no shift, busy stays 0, done=1 for exactly one cycle.
